// File: rtl/mram_bank_wv.sv
// Behavioural MRAM bank: masked write with verify/retry, programmable read latency, BUSY handshake.
// Optional fault injection on write pulses is built when MRAM_FAULT_INJ_EN is defined.
module mram_bank_wv #(
  parameter int ROW_WIDTH    = 8,
  parameter int COL_WIDTH    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ECC_WIDTH    = 20,
  parameter int TOTAL_WIDTH  = DATA_WIDTH + ECC_WIDTH,
  parameter int BEN_WIDTH    = 4,
  parameter int RD_LAT_BASE  = 2,
  parameter int WR_PULSE_CYC = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic                           CLK,
  input  logic                           RSTB,
  input  logic                           CEB,
  input  logic                           WEB,
  input  logic [ROW_WIDTH-1:0]           X,
  input  logic [COL_WIDTH-1:0]           A,
  input  logic [TOTAL_WIDTH-1:0]         Din,
  input  logic [BEN_WIDTH-1:0]           BEN,
  input  logic                           Vclamp,
  input  logic [1:0]                     DELAY_TRIM,
`ifdef MRAM_FAULT_INJ_EN
  input  logic                           FI_ENABLE,
  input  logic [7:0]                     FI_THRESH,
`endif
  output logic [TOTAL_WIDTH-1:0]         OUT,
  output logic                           LAT,
  output logic                           WRC,
  output logic                           WFAIL,
  output logic                           RERR,
  output logic                           BUSY
);

  localparam int AW      = ROW_WIDTH + COL_WIDTH;
  localparam int DEPTH   = 1 << AW;
  localparam int DLW     = DATA_WIDTH / BEN_WIDTH;
  localparam int ELW     = ECC_WIDTH / BEN_WIDTH;
  localparam int CNT_MAX = (RD_LAT_BASE + 3 > WR_PULSE_CYC) ? RD_LAT_BASE + 3 : WR_PULSE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_PULSE, S_VERIFY} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [RTRY_W-1:0]      retry_q;
  logic [AW-1:0]          addr_q;
  logic [TOTAL_WIDTH-1:0] din_q;
  logic [BEN_WIDTH-1:0]   ben_q;
  logic                   vclamp_q;
  logic [TOTAL_WIDTH-1:0] rdata_q;
  logic [TOTAL_WIDTH-1:0] out_q;
  logic                   lat_q, wrc_q, wfail_q, rerr_q;

  // Non-volatile array: zero at power-up only, never touched by reset.
  logic [TOTAL_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic [AW-1:0]          addr_d;
  logic [CNT_W-1:0]       rd_lat_d;
  logic [TOTAL_WIDTH-1:0] mask_d;
  logic                   pulse_end_d;
  logic                   skip_d;
  logic                   commit_d;
  logic                   verify_ok_d;

  assign addr_d      = {X, A};
  assign rd_lat_d    = CNT_W'(RD_LAT_BASE - 1) + CNT_W'(DELAY_TRIM);
  assign pulse_end_d = (state_q == S_PULSE) && (cnt_q == '0);
  assign commit_d    = pulse_end_d && !skip_d;

  always_comb begin
    mask_d = '0;
    for (int unsigned i = 0; i < BEN_WIDTH; i++) begin
      if (ben_q[i]) begin
        mask_d[i*DLW +: DLW]              = '1;
        mask_d[DATA_WIDTH + i*ELW +: ELW] = '1;
      end
    end
  end

`ifdef MRAM_FAULT_INJ_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      lfsr_q <= 16'hACE1;
    end else if (pulse_end_d) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign skip_d      = FI_ENABLE && (lfsr_q[7:0] < FI_THRESH);
  assign verify_ok_d = ((mem_q[addr_q] ^ din_q) & mask_d) == '0;
`else
  assign skip_d      = 1'b0;
  assign verify_ok_d = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (commit_d) begin
      mem_q[addr_q] <= (mem_q[addr_q] & ~mask_d) | (din_q & mask_d);
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      ben_q    <= '0;
      vclamp_q <= 1'b0;
      rdata_q  <= '0;
      out_q    <= '0;
      lat_q    <= 1'b0;
      wrc_q    <= 1'b0;
      wfail_q  <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      lat_q   <= 1'b0;
      wrc_q   <= 1'b0;
      wfail_q <= 1'b0;
      rerr_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!CEB) begin
            addr_q   <= addr_d;
            din_q    <= Din;
            ben_q    <= BEN;
            vclamp_q <= Vclamp;
            retry_q  <= '0;
            if (WEB) begin
              rdata_q <= mem_q[addr_d];
              cnt_q   <= rd_lat_d;
              state_q <= S_READ;
            end else begin
              cnt_q   <= CNT_W'(WR_PULSE_CYC - 1);
              state_q <= S_PULSE;
            end
          end
        end
        S_READ: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            out_q   <= vclamp_q ? rdata_q : '0;
            lat_q   <= 1'b1;
            rerr_q  <= !vclamp_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            state_q <= S_VERIFY;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_VERIFY: begin
          if (verify_ok_d) begin
            state_q <= S_IDLE;
            wrc_q   <= 1'b1;
          end else if (retry_q == RTRY_W'(MAX_RETRY)) begin
            state_q <= S_IDLE;
            wrc_q   <= 1'b1;
            wfail_q <= 1'b1;
          end else begin
            retry_q <= retry_q + 1'b1;
            cnt_q   <= CNT_W'(WR_PULSE_CYC - 1);
            state_q <= S_PULSE;
          end
        end
      endcase
    end
  end

  assign OUT   = out_q;
  assign LAT   = lat_q;
  assign WRC   = wrc_q;
  assign WFAIL = wfail_q;
  assign RERR  = rerr_q;
  assign BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mram_bank_wv.sv
// Self-checking bench for mram_bank_wv against a word-array reference model.
// Fault-injection scenarios run only when MRAM_FAULT_INJ_EN is defined.
module tb_mram_bank_wv;

  localparam int AW     = 10;
  localparam int TW     = 52;
  localparam int BUDGET = 60;

  logic          CLK;
  logic          RSTB;
  logic          CEB;
  logic          WEB;
  logic [7:0]    X;
  logic [1:0]    A;
  logic [TW-1:0] Din;
  logic [3:0]    BEN;
  logic          Vclamp;
  logic [1:0]    DELAY_TRIM;
`ifdef MRAM_FAULT_INJ_EN
  logic          FI_ENABLE;
  logic [7:0]    FI_THRESH;
`endif
  logic [TW-1:0] OUT;
  logic          LAT, WRC, WFAIL, RERR, BUSY;

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] mem_m [1 << AW];

  mram_bank_wv #(
    .ROW_WIDTH(8), .COL_WIDTH(2), .DATA_WIDTH(32), .ECC_WIDTH(20), .TOTAL_WIDTH(52),
    .BEN_WIDTH(4), .RD_LAT_BASE(2), .WR_PULSE_CYC(4), .MAX_RETRY(3)
  ) dut (
    .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .X(X), .A(A), .Din(Din), .BEN(BEN),
    .Vclamp(Vclamp), .DELAY_TRIM(DELAY_TRIM),
`ifdef MRAM_FAULT_INJ_EN
    .FI_ENABLE(FI_ENABLE), .FI_THRESH(FI_THRESH),
`endif
    .OUT(OUT), .LAT(LAT), .WRC(WRC), .WFAIL(WFAIL), .RERR(RERR), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Lane i owns data byte i and ECC bits [32+5i +: 5].
  function automatic logic [TW-1:0] lane_mask(input logic [3:0] ben);
    logic [TW-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (ben[i]) begin
        m[i*8 +: 8]     = '1;
        m[32+i*5 +: 5]  = '1;
      end
    end
    return m;
  endfunction

  function automatic logic [TW-1:0] rand52();
    return TW'({$urandom, $urandom});
  endfunction

  task automatic run_write(input logic [AW-1:0] addr, input logic [TW-1:0] din, input logic [3:0] ben,
                           output int wrc_n, output logic wfail, output int busy_n);
    @(negedge CLK);
    CEB = 1'b0; WEB = 1'b0; {X, A} = addr; Din = din; BEN = ben;
    @(posedge CLK);
    @(negedge CLK);
    CEB = 1'b1; Din = rand52(); BEN = 4'($urandom);
    wrc_n = -1; wfail = 1'b0; busy_n = 0;
    for (int n = 0; n <= BUDGET; n++) begin
      if (n > 0) @(negedge CLK);
      if (BUSY) busy_n++;
      if (WRC) begin
        wrc_n = n; wfail = WFAIL;
        break;
      end
    end
  endtask

  task automatic run_read(input logic [AW-1:0] addr, input logic [1:0] trim, input logic vcl,
                          output int lat_n, output logic [TW-1:0] data, output logic rerr);
    @(negedge CLK);
    CEB = 1'b0; WEB = 1'b1; {X, A} = addr; DELAY_TRIM = trim; Vclamp = vcl; Din = rand52();
    @(posedge CLK);
    @(negedge CLK);
    CEB = 1'b1; DELAY_TRIM = ~trim; Vclamp = ~vcl;
    lat_n = -1; data = '0; rerr = 1'b0;
    for (int n = 0; n <= BUDGET; n++) begin
      if (n > 0) @(negedge CLK);
      if (LAT) begin
        lat_n = n; data = OUT; rerr = RERR;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RSTB = 1'b1; CEB = 1'b1; WEB = 1'b1; X = '0; A = '0; Din = '0; BEN = '0;
    Vclamp = 1'b1; DELAY_TRIM = '0;
`ifdef MRAM_FAULT_INJ_EN
    FI_ENABLE = 1'b0; FI_THRESH = '0;
`endif
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
    #1 RSTB = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (OUT !== '0)    begin errors++; $display("FAIL reset_out: got %0h expected 0", OUT); end
    checks++; if (LAT !== 1'b0)  begin errors++; $display("FAIL reset_lat: got %b expected 0", LAT); end
    checks++; if (WRC !== 1'b0)  begin errors++; $display("FAIL reset_wrc: got %b expected 0", WRC); end
    checks++; if (WFAIL !== 1'b0) begin errors++; $display("FAIL reset_wfail: got %b expected 0", WFAIL); end
    checks++; if (RERR !== 1'b0) begin errors++; $display("FAIL reset_rerr: got %b expected 0", RERR); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    RSTB = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    logic [AW-1:0] addr;
    logic [TW-1:0] d, rd;
    int wrc_n, busy_n, lat_n;
    logic wfail, rerr;
    addr = {8'h12, 2'd1};
    d    = 52'hA_BCDE_1234_5678;
    run_write(addr, d, 4'hF, wrc_n, wfail, busy_n);
    mem_m[addr] = (mem_m[addr] & ~lane_mask(4'hF)) | (d & lane_mask(4'hF));
    checks++; if (wrc_n !== 5)  begin errors++; $display("FAIL basic_wrc_cycle: got %0d expected 5", wrc_n); end
    checks++; if (busy_n !== 5) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 5", busy_n); end
    checks++; if (wfail !== 1'b0) begin errors++; $display("FAIL basic_wfail: got %b expected 0", wfail); end
    run_read(addr, 2'd0, 1'b1, lat_n, rd, rerr);
    checks++; if (lat_n !== 2) begin errors++; $display("FAIL basic_lat_cycle: got %0d expected 2", lat_n); end
    checks++; if (rd !== mem_m[addr]) begin errors++; $display("FAIL basic_rdata: got %0h expected %0h", rd, mem_m[addr]); end
    checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL basic_rerr: got %b expected 0", rerr); end
  endtask

  task automatic test_byte_lanes();
    logic [AW-1:0] addr;
    logic [TW-1:0] exp_w, rd;
    int wrc_n, busy_n, lat_n;
    logic wfail, rerr;
    addr = {8'h12, 2'd1};
    run_write(addr, '1, 4'b0101, wrc_n, wfail, busy_n);
    mem_m[addr] = (mem_m[addr] & ~lane_mask(4'b0101)) | lane_mask(4'b0101);
    exp_w = 52'hA_BCDE_1234_5678;
    exp_w[7:0] = '1;  exp_w[23:16] = '1;  exp_w[36:32] = '1;  exp_w[46:42] = '1;
    checks++; if (wrc_n !== 5) begin errors++; $display("FAIL lanes_wrc_cycle: got %0d expected 5", wrc_n); end
    run_read(addr, 2'd0, 1'b1, lat_n, rd, rerr);
    checks++; if (rd !== exp_w) begin errors++; $display("FAIL lanes_rdata: got %0h expected %0h", rd, exp_w); end
    checks++; if (rd !== mem_m[addr]) begin errors++; $display("FAIL lanes_model: got %0h expected %0h", rd, mem_m[addr]); end
  endtask

  task automatic test_read_latency();
    logic [AW-1:0] addr;
    logic [TW-1:0] rd;
    int lat_n;
    logic rerr;
    addr = {8'h12, 2'd1};
    for (int t = 0; t < 4; t++) begin
      run_read(addr, 2'(t), 1'b1, lat_n, rd, rerr);
      checks++; if (lat_n !== 2 + t) begin errors++; $display("FAIL trim%0d_lat_cycle: got %0d expected %0d", t, lat_n, 2 + t); end
      checks++; if (rd !== mem_m[addr]) begin errors++; $display("FAIL trim%0d_rdata: got %0h expected %0h", t, rd, mem_m[addr]); end
      @(negedge CLK);
      checks++; if (LAT !== 1'b0) begin errors++; $display("FAIL trim%0d_lat_width: got %b expected 0", t, LAT); end
      checks++; if (OUT !== mem_m[addr]) begin errors++; $display("FAIL trim%0d_out_hold: got %0h expected %0h", t, OUT, mem_m[addr]); end
    end
    run_read(addr, 2'd0, 1'b0, lat_n, rd, rerr);
    checks++; if (lat_n !== 2) begin errors++; $display("FAIL noclamp_lat_cycle: got %0d expected 2", lat_n); end
    checks++; if (rd !== '0) begin errors++; $display("FAIL noclamp_rdata: got %0h expected 0", rd); end
    checks++; if (rerr !== 1'b1) begin errors++; $display("FAIL noclamp_rerr: got %b expected 1", rerr); end
    @(negedge CLK);
    checks++; if (RERR !== 1'b0) begin errors++; $display("FAIL noclamp_rerr_width: got %b expected 0", RERR); end
  endtask

  task automatic test_busy_ignore();
    logic [AW-1:0] addr;
    logic [TW-1:0] d1, rd;
    int wrc_n, wrc_cnt, lat_n;
    logic busy5;
    addr = 10'h2A3;
    d1   = rand52();
    @(negedge CLK);
    CEB = 1'b0; WEB = 1'b0; {X, A} = addr; Din = d1; BEN = 4'hF;
    @(posedge CLK);
    @(negedge CLK);
    Din = ~d1;
    wrc_n = -1; wrc_cnt = 0; lat_n = -1; rd = '0; busy5 = 1'b1;
    for (int n = 0; n <= BUDGET; n++) begin
      if (n > 0) @(negedge CLK);
      if (WRC) begin
        wrc_cnt++;
        if (wrc_n < 0) wrc_n = n;
      end
      if (LAT) begin
        lat_n = n; rd = OUT;
        break;
      end
      if (n == 5) begin
        busy5 = BUSY; WEB = 1'b1; DELAY_TRIM = 2'd0; Vclamp = 1'b1;
      end
      if (n == 6) CEB = 1'b1;
    end
    CEB = 1'b1;
    mem_m[addr] = d1;
    checks++; if (wrc_n !== 5) begin errors++; $display("FAIL hold_wrc_cycle: got %0d expected 5", wrc_n); end
    checks++; if (wrc_cnt !== 1) begin errors++; $display("FAIL hold_wrc_count: got %0d expected 1", wrc_cnt); end
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL hold_busy_idle: got %b expected 0", busy5); end
    checks++; if (lat_n !== 8) begin errors++; $display("FAIL hold_next_accept: got %0d expected 8", lat_n); end
    checks++; if (rd !== d1) begin errors++; $display("FAIL hold_rdata: got %0h expected %0h", rd, d1); end
  endtask

  task automatic test_reset_abort();
    logic [AW-1:0] addr;
    logic [TW-1:0] rd;
    int lat_n;
    logic rerr;
    addr = 10'h2A3;
    @(negedge CLK);
    CEB = 1'b0; WEB = 1'b0; {X, A} = addr; Din = ~mem_m[addr]; BEN = 4'hF;
    @(posedge CLK);
    @(negedge CLK);
    CEB = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RSTB = 1'b0;
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
    checks++; if (OUT !== '0) begin errors++; $display("FAIL abort_out: got %0h expected 0", OUT); end
    checks++; if ({LAT, WRC, WFAIL, RERR} !== 4'b0) begin
      errors++; $display("FAIL abort_flags: got %b expected 0000", {LAT, WRC, WFAIL, RERR});
    end
    repeat (3) @(negedge CLK);
    RSTB = 1'b1;
    repeat (6) @(negedge CLK);
    checks++; if (WRC !== 1'b0) begin errors++; $display("FAIL abort_no_wrc: got %b expected 0", WRC); end
    run_read(addr, 2'd1, 1'b1, lat_n, rd, rerr);
    checks++; if (rd !== mem_m[addr]) begin errors++; $display("FAIL abort_old_word: got %0h expected %0h", rd, mem_m[addr]); end
    checks++; if (lat_n !== 3) begin errors++; $display("FAIL abort_lat_cycle: got %0d expected 3", lat_n); end
  endtask

  task automatic test_random();
    logic [AW-1:0] addr;
    logic [TW-1:0] d, rd, exp_d;
    logic [3:0] ben;
    logic [1:0] trim;
    logic vcl, wfail, rerr;
    int wrc_n, busy_n, lat_n;
    for (int it = 0; it < 40; it++) begin
      addr = ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        d   = rand52();
        ben = 4'($urandom);
        run_write(addr, d, ben, wrc_n, wfail, busy_n);
        mem_m[addr] = (mem_m[addr] & ~lane_mask(ben)) | (d & lane_mask(ben));
        checks++; if (wrc_n !== 5) begin errors++; $display("FAIL rnd%0d_wrc_cycle: got %0d expected 5", it, wrc_n); end
        checks++; if (wfail !== 1'b0) begin errors++; $display("FAIL rnd%0d_wfail: got %b expected 0", it, wfail); end
      end else begin
        trim = 2'($urandom_range(0, 3));
        vcl  = ($urandom_range(0, 3) != 0);
        run_read(addr, trim, vcl, lat_n, rd, rerr);
        exp_d = vcl ? mem_m[addr] : '0;
        checks++; if (lat_n !== 2 + int'(trim)) begin errors++; $display("FAIL rnd%0d_lat_cycle: got %0d expected %0d", it, lat_n, 2 + int'(trim)); end
        checks++; if (rd !== exp_d) begin errors++; $display("FAIL rnd%0d_rdata: got %0h expected %0h", it, rd, exp_d); end
        checks++; if (rerr !== !vcl) begin errors++; $display("FAIL rnd%0d_rerr: got %b expected %b", it, rerr, !vcl); end
      end
    end
  endtask

`ifdef MRAM_FAULT_INJ_EN
  task automatic test_fault_inj();
    logic [AW-1:0] addr;
    logic [TW-1:0] d, rd;
    int wrc_n, busy_n, lat_n;
    logic wfail, rerr;
    addr = {8'h12, 2'd1};
    @(negedge CLK);
    RSTB = 1'b0;
    @(negedge CLK);
    RSTB = 1'b1;
    FI_ENABLE = 1'b1; FI_THRESH = 8'hFF;
    d = ~mem_m[addr];
    run_write(addr, d, 4'hF, wrc_n, wfail, busy_n);
    checks++; if (wrc_n !== 20) begin errors++; $display("FAIL fi_wrc_cycle: got %0d expected 20", wrc_n); end
    checks++; if (wfail !== 1'b1) begin errors++; $display("FAIL fi_wfail: got %b expected 1", wfail); end
    checks++; if (busy_n !== 20) begin errors++; $display("FAIL fi_busy_cycles: got %0d expected 20", busy_n); end
    run_read(addr, 2'd0, 1'b1, lat_n, rd, rerr);
    checks++; if (rd !== mem_m[addr]) begin errors++; $display("FAIL fi_word_kept: got %0h expected %0h", rd, mem_m[addr]); end
    FI_THRESH = 8'h00;
    run_write(addr, d, 4'hF, wrc_n, wfail, busy_n);
    mem_m[addr] = d;
    checks++; if (wrc_n !== 5) begin errors++; $display("FAIL fi0_wrc_cycle: got %0d expected 5", wrc_n); end
    checks++; if (wfail !== 1'b0) begin errors++; $display("FAIL fi0_wfail: got %b expected 0", wfail); end
    run_read(addr, 2'd0, 1'b1, lat_n, rd, rerr);
    checks++; if (rd !== d) begin errors++; $display("FAIL fi0_rdata: got %0h expected %0h", rd, d); end
    FI_ENABLE = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_read_latency();
    test_busy_ignore();
    test_reset_abort();
    test_random();
`ifdef MRAM_FAULT_INJ_EN
    test_fault_inj();
`endif
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
